// File: rtl/chain_ctrl_pkg.sv
// rtl/chain_ctrl_pkg.sv - shared state encoding and widths for the chain stimulus controller
package chain_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Default width of the saturating result accumulators.
    localparam int SAT_W_DEFAULT = 32;

endpackage

// File: rtl/xor_sampler.sv
// rtl/xor_sampler.sv - XOR mismatch capture, edge history and saturating accumulators
// CHAIN_CTRL_SYNC_EN selects a two-flop synchronizer instead of a single capture flop.
module xor_sampler
    import chain_ctrl_pkg::*;
#(
    parameter int ACC_W = SAT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xor_in,
    input  logic             clr,
    input  logic             en,
    output logic [ACC_W-1:0] mismatch,
    output logic [ACC_W-1:0] edges
);

    logic samp;
    logic hist;

`ifdef CHAIN_CTRL_SYNC_EN
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            samp <= 1'b0;
        end else begin
            meta <= xor_in;
            samp <= meta;
        end
    end
`else
    // Upstream already registers xor_in; one capture flop suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp <= 1'b0;
        end else begin
            samp <= xor_in;
        end
    end
`endif

    // History runs every cycle so the first enabled cycle sees a true previous sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 1'b0;
        end else begin
            hist <= samp;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch <= '0;
            edges    <= '0;
        end else if (clr) begin
            mismatch <= '0;
            edges    <= '0;
        end else if (en) begin
            if (samp && (mismatch != '1)) begin
                mismatch <= mismatch + ACC_W'(1);
            end
            if (samp && !hist && (edges != '1)) begin
                edges <= edges + ACC_W'(1);
            end
        end
    end

endmodule

// File: rtl/chain_stim_ctrl.sv
// rtl/chain_stim_ctrl.sv - burst stimulus sequencer and mismatch result collector for the inverter-chain pair
// Optional macro CHAIN_CTRL_SYNC_EN: two-flop xor_in synchronizer in xor_sampler.
module chain_stim_ctrl
    import chain_ctrl_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int DIV_W      = 8,
    parameter int ACC_W      = SAT_W_DEFAULT,
    parameter int SETTLE_CYC = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_toggles,
    input  logic [DIV_W-1:0] half_period,
    output logic             stim_out,
    input  logic             xor_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_mismatch,
    output logic [ACC_W-1:0] res_edges
);

    localparam int SC_W = $clog2(SETTLE_CYC);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] tog_cnt;
    logic [DIV_W-1:0] h_lat;
    logic [DIV_W-1:0] div_cnt;
    logic [SC_W-1:0]  win_cnt;
    logic             stim_q;
    logic             win_last;
    logic             div_last;
    logic             tog_last;
    logic             acc_clr;
    logic             acc_en;

    assign win_last = (win_cnt == SC_W'(SETTLE_CYC - 1));
    assign div_last = (div_cnt == h_lat);
    assign tog_last = (tog_cnt == (n_lat - CNT_W'(1)));

    assign acc_clr   = (state == ST_IDLE) && start;
    assign acc_en    = (state == ST_RUN) || (state == ST_DRAIN);
    assign busy      = (state == ST_SETTLE) || (state == ST_RUN) || (state == ST_DRAIN);
    assign res_valid = (state == ST_DONE);
    assign stim_out  = stim_q;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: begin
                if (start) nxt_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (win_last) nxt_state = (n_lat == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (div_last && tog_last) nxt_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (win_last) nxt_state = ST_DONE;
            end
            ST_DONE: begin
                if (res_ready) nxt_state = ST_IDLE;
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    // Window counter is shared by SETTLE and DRAIN; RUN leaves it at zero.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            n_lat   <= '0;
            h_lat   <= '0;
            tog_cnt <= '0;
            div_cnt <= '0;
            win_cnt <= '0;
            stim_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat   <= num_toggles;
                        h_lat   <= half_period;
                        win_cnt <= '0;
                        stim_q  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    win_cnt <= win_last ? '0 : win_cnt + SC_W'(1);
                    div_cnt <= '0;
                    tog_cnt <= '0;
                end
                ST_RUN: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        stim_q  <= ~stim_q;
                        tog_cnt <= tog_cnt + CNT_W'(1);
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_DRAIN: begin
                    win_cnt <= win_last ? '0 : win_cnt + SC_W'(1);
                end
                ST_DONE: begin
                    if (res_ready) stim_q <= 1'b0;
                end
                default: begin
                    stim_q <= 1'b0;
                end
            endcase
        end
    end

    xor_sampler #(
        .ACC_W (ACC_W)
    ) u_sampler (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .xor_in   (xor_in),
        .clr      (acc_clr),
        .en       (acc_en),
        .mismatch (res_mismatch),
        .edges    (res_edges)
    );

endmodule

// File: tb/tb_chain_stim_ctrl.sv
// tb/tb_chain_stim_ctrl.sv - self-checking bench for chain_stim_ctrl against a per-edge xor history model
module tb_chain_stim_ctrl;

    localparam int CNT_W = 16;
    localparam int DIV_W = 8;
    localparam int ACC_W = 32;
    localparam int SC    = 8;
    localparam int MAXC  = 20000;
`ifdef CHAIN_CTRL_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic             sys_clk;
    logic             sys_rst;
    logic             start;
    logic [CNT_W-1:0] num_toggles;
    logic [DIV_W-1:0] half_period;
    logic             stim_out;
    logic             xor_in;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_mismatch;
    logic [ACC_W-1:0] res_edges;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic xhist [MAXC];

    typedef struct {
        int n;
        int h;
        int pat;
        int em;
        int ee;
        int hold;
        int chain;
    } vec_t;

    vec_t vecs[6];

    chain_stim_ctrl #(
        .CNT_W      (CNT_W),
        .DIV_W      (DIV_W),
        .ACC_W      (ACC_W),
        .SETTLE_CYC (SC)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .num_toggles  (num_toggles),
        .half_period  (half_period),
        .stim_out     (stim_out),
        .xor_in       (xor_in),
        .busy         (busy),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_mismatch (res_mismatch),
        .res_edges    (res_edges)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Record the xor_in value seen by each rising edge; edge index == cyc at that edge.
    always @(posedge sys_clk) begin
        if (cyc < MAXC) xhist[cyc] <= xor_in;
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value of xor_in for the edge following offset d (pattern 3: five single-cycle pulses in RUN).
    function automatic logic xval(input int pat, input int d);
        case (pat)
            0: return 1'b0;
            1: return 1'b1;
            2: return 1'($urandom_range(0, 1));
            default: return (d >= SC) && (d < SC + 20) && (((d - SC) % 4) == 1);
        endcase
    endfunction

    task automatic do_run(input vec_t v);
        int k, nw, tot, t, mm, ed;
        logic [ACC_W-1:0] held_mm, held_ed;
        nw  = v.n * (v.h + 1);
        tot = 2 * SC + nw;
        num_toggles = CNT_W'(v.n);
        half_period = DIV_W'(v.h);
        start  = 1'b1;
        xor_in = xval(v.pat, -1);
        k = cyc;
        for (int d = 0; d <= tot; d++) begin
            @(negedge sys_clk);
            start = 1'b0;
            num_toggles = CNT_W'($urandom);
            half_period = DIV_W'($urandom);
            chk("busy", busy, (d < tot) ? 1 : 0);
            chk("res_valid", res_valid, (d >= tot) ? 1 : 0);
            if (d < SC) begin
                t = 0;
            end else begin
                t = (d - SC) / (v.h + 1);
                if (t > v.n) t = v.n;
            end
            chk("stim_out", stim_out, t % 2);
            xor_in = xval(v.pat, d);
        end
        mm = 0;
        ed = 0;
        for (int e = k + SC + 1; e <= k + tot; e++) begin
            mm += int'(xhist[e - S]);
            if (xhist[e - S] && !xhist[e - S - 1]) ed++;
        end
        chk("res_mismatch_model", res_mismatch, mm);
        chk("res_edges_model", res_edges, ed);
        if (v.em >= 0) chk("res_mismatch_const", res_mismatch, v.em);
        if (v.ee >= 0) chk("res_edges_const", res_edges, v.ee);
        held_mm = res_mismatch;
        held_ed = res_edges;
        for (int i = 0; i < v.hold; i++) begin
            start  = (i == 3) ? 1'b1 : 1'b0;
            xor_in = 1'($urandom_range(0, 1));
            @(negedge sys_clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_busy", busy, 0);
            chk("hold_stim", stim_out, v.n % 2);
            chk("hold_mismatch", res_mismatch, held_mm);
            chk("hold_edges", res_edges, held_ed);
        end
        res_ready = 1'b1;
        start = (v.chain != 0);
        @(negedge sys_clk);
        res_ready = 1'b0;
        chk("post_valid", res_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_stim", stim_out, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        vecs[0] = '{n: 4,  h: 1, pat: 1, em: 16, ee: 0, hold: 0,  chain: 0};
        vecs[1] = '{n: 3,  h: 0, pat: 0, em: 0,  ee: 0, hold: 0,  chain: 0};
        vecs[2] = '{n: 0,  h: 2, pat: 0, em: 0,  ee: 0, hold: 0,  chain: 0};
        vecs[3] = '{n: 10, h: 1, pat: 3, em: 5,  ee: 5, hold: 0,  chain: 0};
        vecs[4] = '{n: 2,  h: 1, pat: 2, em: -1, ee: -1, hold: 10, chain: 1};
        vecs[5] = '{n: 5,  h: 2, pat: 2, em: -1, ee: -1, hold: 2,  chain: 0};

        sys_rst = 1'b1;
        start = 1'b0;
        num_toggles = '0;
        half_period = '0;
        xor_in = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_stim", stim_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_mismatch", res_mismatch, 0);
        chk("rst_edges", res_edges, 0);
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        foreach (vecs[i]) do_run(vecs[i]);

        // Abort mid-RUN: at offset SC+3 with H=2 one toggle has happened.
        num_toggles = 16'd6;
        half_period = 8'd2;
        start = 1'b1;
        xor_in = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (SC + 3) @(negedge sys_clk);
        chk("prerst_stim", stim_out, 1);
        chk("prerst_busy", busy, 1);
        #2 sys_rst = 1'b1;
        #1;
        chk("async_rst_stim", stim_out, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", res_valid, 0);
        chk("async_rst_mismatch", res_mismatch, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("after_rst_busy", busy, 0);
        rv = '{n: 2, h: 0, pat: 2, em: -1, ee: -1, hold: 0, chain: 0};
        do_run(rv);

        for (int i = 0; i < 6; i++) begin
            rv.n = int'($urandom_range(0, 9));
            rv.h = int'($urandom_range(0, 3));
            rv.pat = (i == 5) ? 3 : 2;
            rv.em = -1;
            rv.ee = -1;
            rv.hold = int'($urandom_range(0, 4));
            rv.chain = 0;
            if (rv.pat == 3) rv.n = 12;
            do_run(rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
